cart_mem_arbiter: RTL and testbench

- Shares one single-port cartridge memory between two requesters: the ioctl download loader (byte writes) and the console cartridge port (byte reads).
- Sits between the ioctl interface, cv_console's cart_a/cart_rd/cart_d port and the cart memory (SPRAM in simulation, SDRAM on hardware).
- Back-pressures the loader with ioctl_wait and tracks the highest 16 KB page loaded, driving cart_pages.

---
 rtl/cart_mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter
//   Shares one single-port cartridge memory between the ioctl download loader
//   (byte writes) and the console cartridge port (byte reads).
//
//   Each requester has a one-entry buffer. Arbitration is decided at the
//   clock edge that captures a request, so commands leave on registered
//   outputs one cycle after the strobe.
//
// Parameters
//   AW      cart byte-address width (ioctl_addr[19:14] is the page, so AW >= 20)
//   RD_LAT  cycles from mem_re to valid mem_rdata (1..4)
//
// Ports
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   ioctl_download/wr/addr/dout loader side; ioctl_wait = write buffer full
//   cart_rd, cart_a             console read strobe and address
//   cart_d, cart_valid          read data (held) and one-cycle update pulse
//   cart_pages                  highest 16 KB page written in this download
//   mem_ready                   memory accepts a command this cycle
//   mem_addr/we/re/wdata/rdata  memory command and data
//   wr_overflow                 sticky: write strobe dropped on a full buffer
module cart_mem_arbiter #(
  parameter int AW     = 20,
  parameter int RD_LAT = 2
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  input  logic          cart_rd,
  input  logic [AW-1:0] cart_a,
  output logic [7:0]    cart_d,
  output logic          cart_valid,
  output logic [5:0]    cart_pages,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          wr_overflow
);

  localparam int CW = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_RDWAIT} state_t;

  state_t          state_reg, state_next;
  logic            wbuf_full_reg, wbuf_full_next;
  logic [AW-1:0]   wbuf_addr_reg, wbuf_addr_next;
  logic [7:0]      wbuf_data_reg, wbuf_data_next;
  logic            rbuf_pend_reg, rbuf_pend_next;
  logic [AW-1:0]   rbuf_addr_reg, rbuf_addr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [7:0]      cart_d_reg, cart_d_next;
  logic            cart_valid_reg, cart_valid_next;
  logic [5:0]      pages_reg, pages_next;
  logic            dl_prev_reg, dl_prev_next;
  logic [AW-1:0]   mem_addr_reg, mem_addr_next;
  logic            mem_we_reg, mem_we_next;
  logic            mem_re_reg, mem_re_next;
  logic [7:0]      mem_wdata_reg, mem_wdata_next;
  logic            overflow_reg, overflow_next;

  logic            wr_accept;
  logic [5:0]      wr_page;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      wbuf_full_reg  <= 1'b0;
      wbuf_addr_reg  <= '0;
      wbuf_data_reg  <= '0;
      rbuf_pend_reg  <= 1'b0;
      rbuf_addr_reg  <= '0;
      cnt_reg        <= '0;
      cart_d_reg     <= '0;
      cart_valid_reg <= 1'b0;
      pages_reg      <= '0;
      dl_prev_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_we_reg     <= 1'b0;
      mem_re_reg     <= 1'b0;
      mem_wdata_reg  <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wbuf_full_reg  <= wbuf_full_next;
      wbuf_addr_reg  <= wbuf_addr_next;
      wbuf_data_reg  <= wbuf_data_next;
      rbuf_pend_reg  <= rbuf_pend_next;
      rbuf_addr_reg  <= rbuf_addr_next;
      cnt_reg        <= cnt_next;
      cart_d_reg     <= cart_d_next;
      cart_valid_reg <= cart_valid_next;
      pages_reg      <= pages_next;
      dl_prev_reg    <= dl_prev_next;
      mem_addr_reg   <= mem_addr_next;
      mem_we_reg     <= mem_we_next;
      mem_re_reg     <= mem_re_next;
      mem_wdata_reg  <= mem_wdata_next;
      overflow_reg   <= overflow_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wbuf_full_next  = wbuf_full_reg;
    wbuf_addr_next  = wbuf_addr_reg;
    wbuf_data_next  = wbuf_data_reg;
    rbuf_pend_next  = rbuf_pend_reg;
    rbuf_addr_next  = rbuf_addr_reg;
    cnt_next        = cnt_reg;
    cart_d_next     = cart_d_reg;
    cart_valid_next = 1'b0;
    pages_next      = pages_reg;
    dl_prev_next    = ioctl_download;
    mem_addr_next   = mem_addr_reg;
    mem_we_next     = 1'b0;
    mem_re_next     = 1'b0;
    mem_wdata_next  = mem_wdata_reg;
    overflow_next   = overflow_reg;
    wr_page         = ioctl_addr[19:14];

    // The WRITE cycle drains the buffer, so a strobe landing in that cycle
    // can refill it; any other strobe on a full buffer is lost.
    wr_accept = ioctl_wr && (!wbuf_full_reg || state_reg == ST_WRITE);

    if (state_reg == ST_WRITE) begin
      wbuf_full_next = 1'b0;
    end
    if (wr_accept) begin
      wbuf_full_next = 1'b1;
      wbuf_addr_next = ioctl_addr;
      wbuf_data_next = ioctl_dout;
    end
    if (ioctl_wr && !wr_accept) begin
      overflow_next = 1'b1;
    end

    // Pending clears in the mem_re cycle; a strobe in that same cycle queues
    // the next read. Before issue, a new strobe just replaces the address.
    if (state_reg == ST_RDWAIT && mem_re_reg) begin
      rbuf_pend_next = 1'b0;
    end
    if (cart_rd) begin
      rbuf_pend_next = 1'b1;
      rbuf_addr_next = cart_a;
    end

    if (ioctl_download && !dl_prev_reg) begin
      pages_next = '0;
    end
    if (wr_accept && wr_page > pages_next) begin
      pages_next = wr_page;
    end

    unique case (state_reg)
      ST_IDLE: begin
        // Arbitrate on the post-capture buffer contents so a request
        // arriving this cycle is issued on the very next cycle.
        if (mem_ready) begin
          if (wbuf_full_next && (ioctl_download || !rbuf_pend_next)) begin
            state_next     = ST_WRITE;
            mem_we_next    = 1'b1;
            mem_addr_next  = wbuf_addr_next;
            mem_wdata_next = wbuf_data_next;
          end else if (rbuf_pend_next) begin
            state_next    = ST_RDWAIT;
            mem_re_next   = 1'b1;
            mem_addr_next = rbuf_addr_next;
            cnt_next      = CW'(RD_LAT);
          end
        end
      end
      ST_WRITE: begin
        state_next = ST_IDLE;
      end
      ST_RDWAIT: begin
        // The counter reaches 0 in the cycle mem_rdata is valid.
        if (cnt_reg == '0) begin
          cart_d_next     = mem_rdata;
          cart_valid_next = 1'b1;
          state_next      = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign ioctl_wait  = wbuf_full_reg;
  assign cart_d      = cart_d_reg;
  assign cart_valid  = cart_valid_reg;
  assign cart_pages  = pages_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_we      = mem_we_reg;
  assign mem_re      = mem_re_reg;
  assign mem_wdata   = mem_wdata_reg;
  assign wr_overflow = overflow_reg;

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter. A small memory model answers reads
// RD_LAT cycles after mem_re; unwritten addresses return a pattern derived
// from the address, and 0xEE outside the valid data cycle.
module tb_cart_mem_arbiter;

  localparam int AW     = 20;
  localparam int RD_LAT = 2;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          ioctl_wait;
  logic          cart_rd;
  logic [AW-1:0] cart_a;
  logic [7:0]    cart_d;
  logic          cart_valid;
  logic [5:0]    cart_pages;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          wr_overflow;

  int n_cmp;
  int n_bad;
  int n_re;
  int n_vld;
  int re_base;
  int vld_base;

  always #5 clk_sys = ~clk_sys;

  cart_mem_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .cart_rd        (cart_rd),
    .cart_a         (cart_a),
    .cart_d         (cart_d),
    .cart_valid     (cart_valid),
    .cart_pages     (cart_pages),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .wr_overflow    (wr_overflow)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem_model [logic [19:0]];
  logic [7:0] rd_dat [0:RD_LAT-1];
  logic       rd_vld [0:RD_LAT-1];

  function automatic logic [7:0] model_rd(input logic [19:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk_sys) begin
    if (mem_we) mem_model[mem_addr] = mem_wdata;
    rd_vld[0] <= mem_re;
    rd_dat[0] <= mem_re ? model_rd(mem_addr) : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld[i] <= rd_vld[i-1];
      rd_dat[i] <= rd_dat[i-1];
    end
  end

  assign mem_rdata = rd_vld[RD_LAT-1] ? rd_dat[RD_LAT-1] : 8'hEE;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; tally command/valid pulses
  // and confirm the two commands never overlap.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (mem_re) n_re++;
    if (cart_valid) n_vld++;
    chk("excl_we_re", 32'(mem_we & mem_re), 0);
  endtask

  task automatic wr_page(input logic [19:0] a, input logic [7:0] d, input int exp_pages);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
    $display("txn: page write addr=%05h -> cart_pages=%0d", a, cart_pages);
    chk("pages_after_wr", 32'(cart_pages), exp_pages);
    tick();
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wait"},  32'(ioctl_wait),  0);
    chk({tag, "_valid"}, 32'(cart_valid),  0);
    chk({tag, "_we"},    32'(mem_we),      0);
    chk({tag, "_re"},    32'(mem_re),      0);
    chk({tag, "_ovf"},   32'(wr_overflow), 0);
    chk({tag, "_d"},     32'(cart_d),      0);
    chk({tag, "_pages"}, 32'(cart_pages),  0);
    chk({tag, "_addr"},  32'(mem_addr),    0);
    chk({tag, "_wdata"}, 32'(mem_wdata),   0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp = 0; n_bad = 0; n_re = 0; n_vld = 0;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cart_rd = 1'b0; cart_a = '0;
    mem_ready = 1'b1;
    #1;
    $display("txn: power-on reset");
    chk_reset_outputs("por");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single write then read-back.
    ioctl_download = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = 20'h04000; ioctl_dout = 8'hA5;
    tick(); ioctl_wr = 1'b0;
    $display("txn: write 04000=A5");
    chk("wr1_we",    32'(mem_we),    1);
    chk("wr1_addr",  32'(mem_addr),  'h04000);
    chk("wr1_wdata", 32'(mem_wdata), 'hA5);
    chk("wr1_wait",  32'(ioctl_wait), 1);
    chk("wr1_re",    32'(mem_re),    0);
    tick();
    chk("wr1_we_c2",   32'(mem_we),     0);
    chk("wr1_wait_c2", 32'(ioctl_wait), 0);
    chk("wr1_pages",   32'(cart_pages), 1);
    ioctl_download = 1'b0;
    tick();
    cart_rd = 1'b1; cart_a = 20'h04000;
    tick(); cart_rd = 1'b0;
    $display("txn: read 04000");
    chk("rd1_re",   32'(mem_re),   1);
    chk("rd1_addr", 32'(mem_addr), 'h04000);
    tick(); chk("rd1_valid_c2", 32'(cart_valid), 0);
    tick(); chk("rd1_valid_c3", 32'(cart_valid), 0);
    tick();
    chk("rd1_valid_c4", 32'(cart_valid), 1);
    chk("rd1_data",     32'(cart_d),     'hA5);
    tick();
    chk("rd1_valid_c5", 32'(cart_valid), 0);
    chk("rd1_hold",     32'(cart_d),     'hA5);
    chk("pages_hold",   32'(cart_pages), 1);

    // Priority while downloading: write goes first.
    ioctl_download = 1'b1;
    ioctl_wr = 1'b1; ioctl_addr = 20'h00200; ioctl_dout = 8'h3C;
    cart_rd = 1'b1; cart_a = 20'h00300;
    tick(); ioctl_wr = 1'b0; cart_rd = 1'b0;
    $display("txn: simultaneous wr 00200=3C / rd 00300, download=1");
    chk("pw_we",    32'(mem_we),     1);
    chk("pw_re",    32'(mem_re),     0);
    chk("pw_addr",  32'(mem_addr),   'h00200);
    chk("pw_pages", 32'(cart_pages), 0);
    tick();
    chk("pw_we_c2", 32'(mem_we), 0);
    chk("pw_re_c2", 32'(mem_re), 0);
    tick();
    chk("pw_re_c3",   32'(mem_re),   1);
    chk("pw_raddr",   32'(mem_addr), 'h00300);
    tick(); tick();
    chk("pw_valid_c5", 32'(cart_valid), 0);
    tick();
    chk("pw_valid_c6", 32'(cart_valid), 1);
    chk("pw_data",     32'(cart_d),     'h59);
    tick();

    // Priority without download: read goes first, write after cart_valid.
    ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 20'h00400; ioctl_dout = 8'h77;
    cart_rd = 1'b1; cart_a = 20'h00200;
    tick(); ioctl_wr = 1'b0; cart_rd = 1'b0;
    $display("txn: simultaneous wr 00400=77 / rd 00200, download=0");
    chk("pr_re",    32'(mem_re),     1);
    chk("pr_we",    32'(mem_we),     0);
    chk("pr_addr",  32'(mem_addr),   'h00200);
    chk("pr_wait",  32'(ioctl_wait), 1);
    tick(); tick(); tick();
    chk("pr_valid",   32'(cart_valid), 1);
    chk("pr_data",    32'(cart_d),     'h3C);
    chk("pr_we_c4",   32'(mem_we),     0);
    chk("pr_wait_c4", 32'(ioctl_wait), 1);
    tick();
    chk("pr_we_c5",  32'(mem_we),    1);
    chk("pr_waddr",  32'(mem_addr),  'h00400);
    chk("pr_wdata",  32'(mem_wdata), 'h77);
    tick();
    chk("pr_wait_c6", 32'(ioctl_wait), 0);

    // Stall with a buffered write, plus an overflowing second strobe.
    mem_ready = 1'b0;
    ioctl_wr = 1'b1; ioctl_addr = 20'h00500; ioctl_dout = 8'h11;
    tick();
    $display("txn: stalled write 00500=11");
    chk("st_wait_c1", 32'(ioctl_wait),  1);
    chk("st_we_c1",   32'(mem_we),      0);
    chk("st_ovf_c1",  32'(wr_overflow), 0);
    ioctl_addr = 20'h00600; ioctl_dout = 8'h22;
    tick(); ioctl_wr = 1'b0;
    $display("txn: overflow write 00600=22");
    chk("st_ovf_c2", 32'(wr_overflow), 1);
    for (int c = 2; c <= 5; c++) begin
      chk("st_wait", 32'(ioctl_wait), 1);
      chk("st_we",   32'(mem_we),     0);
      if (c < 5) tick();
    end
    mem_ready = 1'b1;
    tick();
    chk("st_we_go",  32'(mem_we),    1);
    chk("st_waddr",  32'(mem_addr),  'h00500);
    chk("st_wdata",  32'(mem_wdata), 'h11);
    tick();
    chk("st_wait_done", 32'(ioctl_wait),  0);
    chk("st_ovf_stick", 32'(wr_overflow), 1);

    // cart_pages tracking.
    ioctl_download = 1'b1;
    wr_page(20'h0C000, 8'h01, 3);
    wr_page(20'h1C000, 8'h02, 7);
    wr_page(20'h08000, 8'h03, 7);
    ioctl_download = 1'b0;
    tick();
    chk("pages_after_dl", 32'(cart_pages), 7);
    ioctl_download = 1'b1;
    tick();
    $display("txn: new download starts");
    chk("pages_new_dl", 32'(cart_pages), 0);
    ioctl_download = 1'b0;
    tick();

    // Read coalescing while the memory is busy.
    mem_ready = 1'b0;
    cart_rd = 1'b1; cart_a = 20'h00010;
    tick();
    cart_a = 20'h00020;
    tick(); cart_rd = 1'b0;
    $display("txn: coalesced reads 00010, 00020");
    chk("co_re_stall", 32'(mem_re), 0);
    mem_ready = 1'b1;
    re_base = n_re; vld_base = n_vld;
    tick();
    chk("co_re",   32'(mem_re),   1);
    chk("co_addr", 32'(mem_addr), 'h00020);
    tick(); tick(); tick();
    chk("co_valid", 32'(cart_valid), 1);
    chk("co_data",  32'(cart_d),     'h7A);
    repeat (4) tick();
    chk("co_n_re",  n_re - re_base,   1);
    chk("co_n_vld", n_vld - vld_base, 1);

    // Reset in the middle of a read.
    cart_rd = 1'b1; cart_a = 20'h00100;
    tick(); cart_rd = 1'b0;
    $display("txn: read 00100 interrupted by reset");
    chk("rr_re", 32'(mem_re), 1);
    re_base = n_re; vld_base = n_vld;
    tick();
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("rr");
    tick(); tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("rr_no_valid", n_vld - vld_base, 0);
    chk("rr_no_re",    n_re - re_base,   0);
    cart_rd = 1'b1; cart_a = 20'h00200;
    tick(); cart_rd = 1'b0;
    $display("txn: read 00200 after reset");
    chk("ar_re", 32'(mem_re), 1);
    tick(); tick(); tick();
    chk("ar_valid", 32'(cart_valid), 1);
    chk("ar_data",  32'(cart_d),     'h3C);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
